fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences the instruction-fetch stage.
- Owns the 12-bit program counter and issues instruction-memory requests over a req/ack handshake.
- Drives the next-PC select: sequential PC+1, or an 8-bit branch target zero-extended to 12 bits.
- Delivers fetched instructions to decode with valid/stall flow control and squashes wrong-path fetches on a branch.

Parameters:
- ADDR_W, 12, PC and instruction-memory address width.
- TGT_W, 8, branch-target width; zero-extended to ADDR_W.
- INSTR_W, 32, instruction word width.
- RESET_PC, 12'h000, PC value loaded on reset.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- branch_taken  in  1  redirect request from execute; one-cycle pulse.
- branch_target  in  TGT_W  redirect address; valid when branch_taken=1.
- stall  in  1  decode cannot accept the instruction this cycle.
- halt  in  1  stop fetching after the current instruction is consumed.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  ADDR_W  request address; equals pc.
- imem_ack  in  1  memory response valid.
- imem_rdata  in  INSTR_W  response data.
- pc_sel  out  1  next-PC select: 1 = zero-extended branch_target, 0 = pc+1.
- instr_valid  out  1  instr/instr_pc valid for decode.
- instr  out  INSTR_W  delivered instruction.
- instr_pc  out  ADDR_W  address of the delivered instruction.
- halted  out  1  high in HALTED.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0, halted=0, squash flag=0.
- IDLE: one cycle, then go to REQ. No request in IDLE.
- REQ:
  - imem_req=1 and imem_addr=pc, held stable until imem_ack.
  - On imem_ack with no squash pending: capture imem_rdata into instr and pc into instr_pc, go to DELIVER. instr_valid rises the cycle after the ack (1-cycle capture latency).
  - On imem_ack with squash pending: discard the data, clear squash, load the redirected pc, stay in REQ. The new address is presented the next cycle, and imem_req deasserts for that one cycle.
- DELIVER:
  - instr_valid=1; instr and instr_pc are held while stall=1.
  - Consumed means instr_valid & !stall.
  - On consume: pc <= pc+1 with wrap, 12'hFFF+1 = 12'h000.
  - On consume with halt=1: go to HALTED. Otherwise go to REQ.
- HALTED: imem_req=0, instr_valid=0, halted=1. Only rst exits this state.
- Branch redirect (branch_taken=1), pc <= {0, branch_target} next cycle, pc_sel=1 that cycle:
  - In IDLE: no request is outstanding, so no squash.
  - In REQ with no ack the same cycle: set squash, so the pending response is dropped. The redirect is applied when that ack arrives.
  - In REQ with imem_ack the same cycle: drop the data, load the target, re-request.
  - In DELIVER: instr_valid=0 next cycle (delivered instruction squashed even if stalled), go to REQ.
  - In HALTED: ignored.
- Priority: branch_taken over halt over sequential increment. If branch and halt coincide in DELIVER, the branch wins and halt is ignored.
- pc_sel=0 whenever branch_taken=0.
- Only one request is ever outstanding; the block never issues a second request before the ack.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt[15:0] and squash_cnt[15:0], both reset to 0.
  - fetch_cnt increments on every consumed instruction; squash_cnt increments on every discarded ack or squashed DELIVER.
  - Both saturate at 16'hFFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg:
  - ADDR_W/TGT_W/INSTR_W constants.
  - RESET_PC.
  - state enum fetch_state_t {IDLE, REQ, DELIVER, HALTED}.
- Sub-module fetch_next_pc (combinational): inputs pc, branch_target, pc_sel; output next_pc. sel=1 gives {4'b0, target}; sel=0 gives pc+1 with wrap.

Test Plan:
- Reset then zero-latency ack on every request: imem_addr sequence 000,001,002.
  - instr_valid pulses carry instr_pc 000,001,002.
  - instr matches the memory model.
- stall=1 for 3 cycles in DELIVER at pc 005: instr/instr_pc held, no new imem_req. After release, the next request address is 006.
- branch_taken with target 8'hA5 while REQ waits 2 cycles for ack:
  - the response is dropped and instr_valid never rises for the old pc;
  - the next imem_addr is 12'h0A5; squash_cnt=1 if the macro is enabled.
- branch_taken in DELIVER at pc 010 with target 8'h20: that instruction is squashed, the next request is 0x020, and pc_sel=1 for exactly one cycle.
- PC preloaded to 12'hFFF: after consume, the next imem_addr is 12'h000.
- halt with consume at pc 003: halted=1, imem_req stays 0 for 20 cycles. rst asserted mid-REQ clears all outputs immediately (async) and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned TGT_W   = 8;
  localparam int unsigned INSTR_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 12'h000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DELIVER,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC mux: zero-extended branch target or sequential pc+1 with natural wrap.
module fetch_next_pc #(
  parameter int unsigned ADDR_W = fetch_pkg::ADDR_W,
  parameter int unsigned TGT_W  = fetch_pkg::TGT_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [TGT_W-1:0]  branch_target,
  input  logic              pc_sel,
  output logic [ADDR_W-1:0] next_pc
);

  always_comb begin
    if (pc_sel) begin
      next_pc = {{(ADDR_W-TGT_W){1'b0}}, branch_target};
    end else begin
      next_pc = pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: PC ownership, imem req/ack, decode delivery, branch squash.
// Optional perf counters (fetch_cnt/squash_cnt) are enabled by defining FETCH_PERF_CNT_EN.
module fetch_sequencer #(
  parameter int unsigned        ADDR_W   = fetch_pkg::ADDR_W,
  parameter int unsigned        TGT_W    = fetch_pkg::TGT_W,
  parameter int unsigned        INSTR_W  = fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_taken,
  input  logic [TGT_W-1:0]   branch_target,
  input  logic               stall,
  input  logic               halt,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               pc_sel,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]        fetch_cnt,
  output logic [15:0]        squash_cnt,
`endif
  output logic               halted
);

  import fetch_pkg::*;

  fetch_state_t       state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  next_pc;
  logic               squash;
  logic [TGT_W-1:0]   pend_tgt;
  logic               ack_hit;
  logic               load_pend;
  logic               mux_sel;
  logic [TGT_W-1:0]   mux_tgt;

  assign imem_addr = pc;
  assign pc_sel    = branch_taken & (state != HALTED);
  assign ack_hit   = (state == REQ) & imem_req & imem_ack;

  // A redirect seen while a request is in flight is parked in pend_tgt and
  // applied on that request's ack; a same-cycle branch overrides it.
  assign load_pend = ack_hit & squash & ~branch_taken;
  assign mux_sel   = pc_sel | load_pend;
  assign mux_tgt   = branch_taken ? branch_target : pend_tgt;

  fetch_next_pc #(
    .ADDR_W (ADDR_W),
    .TGT_W  (TGT_W)
  ) u_next_pc (
    .pc            (pc),
    .branch_target (mux_tgt),
    .pc_sel        (mux_sel),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      squash      <= 1'b0;
      pend_tgt    <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (branch_taken) pc <= next_pc;
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (!imem_req) begin
            // Re-request gap after a discarded response: nothing outstanding.
            if (branch_taken) pc <= next_pc;
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            imem_req <= 1'b0;
            if (squash || branch_taken) begin
              pc     <= next_pc;
              squash <= 1'b0;
            end else begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              state       <= DELIVER;
            end
          end else if (branch_taken) begin
            squash   <= 1'b1;
            pend_tgt <= branch_target;
          end
        end
        DELIVER: begin
          if (branch_taken) begin
            instr_valid <= 1'b0;
            pc          <= next_pc;
            state       <= REQ;
            imem_req    <= 1'b1;
          end else if (!stall) begin
            instr_valid <= 1'b0;
            pc          <= next_pc;
            if (halt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state    <= REQ;
              imem_req <= 1'b1;
            end
          end
        end
        HALTED: begin
          halted <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic consume;
  logic discard;

  assign consume = (state == DELIVER) & ~branch_taken & ~stall;
  assign discard = (ack_hit & (squash | branch_taken)) |
                   ((state == DELIVER) & branch_taken);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (consume && fetch_cnt != '1)  fetch_cnt  <= fetch_cnt + 1'b1;
      if (discard && squash_cnt != '1) squash_cnt <= squash_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a combinational memory responder.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        stall, halt;
  logic        ack_en;
  logic        imem_req, imem_ack, pc_sel, instr_valid, halted;
  logic [11:0] imem_addr, instr_pc;
  logic [31:0] imem_rdata, instr;

  logic        imem_req2, pc_sel2, instr_valid2, halted2, imem_ack2;
  logic [11:0] imem_addr2, instr_pc2;
  logic [31:0] imem_rdata2, instr2;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt, squash_cnt, fetch_cnt2, squash_cnt2;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [11:0] a);
    return {20'hC0DE5, a};
  endfunction

  assign imem_ack    = ack_en & imem_req;
  assign imem_rdata  = mem(imem_addr);
  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = mem(imem_addr2);

  fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .halt          (halt),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc_sel        (pc_sel),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt     (fetch_cnt),
    .squash_cnt    (squash_cnt),
`endif
    .halted        (halted)
  );

  fetch_sequencer #(
    .RESET_PC (12'hFFF)
  ) dut_wrap (
    .clk           (clk),
    .rst           (rst2),
    .branch_taken  (1'b0),
    .branch_target (8'h00),
    .stall         (1'b0),
    .halt          (1'b0),
    .imem_req      (imem_req2),
    .imem_addr     (imem_addr2),
    .imem_ack      (imem_ack2),
    .imem_rdata    (imem_rdata2),
    .pc_sel        (pc_sel2),
    .instr_valid   (instr_valid2),
    .instr         (instr2),
    .instr_pc      (instr_pc2),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt     (fetch_cnt2),
    .squash_cnt    (squash_cnt2),
`endif
    .halted        (halted2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; ack_en = 1'b1;
    branch_taken = 1'b0; branch_target = 8'h00; stall = 1'b0; halt = 1'b0;
    tick(); tick();
    chk("rst_req",    {31'b0, imem_req},    32'h0);
    chk("rst_valid",  {31'b0, instr_valid}, 32'h0);
    chk("rst_instr",  instr,                32'h0);
    chk("rst_ipc",    {20'b0, instr_pc},    32'h0);
    chk("rst_halted", {31'b0, halted},      32'h0);
    chk("rst_addr",   {20'b0, imem_addr},   32'h000);

    // Zero-latency acks: sequential fetch 000..004.
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("seq_req",  {31'b0, imem_req},  32'h1);
      chk("seq_addr", {20'b0, imem_addr}, i);
      tick();
      chk("seq_valid", {31'b0, instr_valid}, 32'h1);
      chk("seq_ipc",   {20'b0, instr_pc},    i);
      chk("seq_instr", instr,                mem(12'(i)));
      chk("seq_noreq", {31'b0, imem_req},    32'h0);
      tick();
    end

    // Stall three cycles while delivering pc 005.
    chk("st_addr", {20'b0, imem_addr}, 32'h005);
    stall = 1'b1;
    tick();
    chk("st_ipc0", {20'b0, instr_pc}, 32'h005);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_valid", {31'b0, instr_valid}, 32'h1);
      chk("st_ipc",   {20'b0, instr_pc},    32'h005);
      chk("st_instr", instr,                32'hC0DE5005);
      chk("st_noreq", {31'b0, imem_req},    32'h0);
    end
    stall = 1'b0;
    tick();
    chk("st_next_req",  {31'b0, imem_req},  32'h1);
    chk("st_next_addr", {20'b0, imem_addr}, 32'h006);

    // Branch while the request to 006 waits two cycles for its ack.
    ack_en = 1'b0;
    branch_taken = 1'b1; branch_target = 8'hA5;
    #1;
    chk("bq_pcsel1", {31'b0, pc_sel}, 32'h1);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("bq_pcsel0", {31'b0, pc_sel},      32'h0);
    chk("bq_hold1",  {20'b0, imem_addr},   32'h006);
    chk("bq_req1",   {31'b0, imem_req},    32'h1);
    tick();
    chk("bq_hold2",  {20'b0, imem_addr},   32'h006);
    ack_en = 1'b1;
    tick();
    chk("bq_gap_req",  {31'b0, imem_req},    32'h0);
    chk("bq_gap_addr", {20'b0, imem_addr},   32'h0A5);
    chk("bq_novalid",  {31'b0, instr_valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("bq_sqcnt", {16'b0, squash_cnt}, 32'h1);
`endif
    tick();
    chk("bq_req2",  {31'b0, imem_req},  32'h1);
    chk("bq_addr2", {20'b0, imem_addr}, 32'h0A5);
    tick();
    chk("bq_dlv_ipc",   {20'b0, instr_pc}, 32'h0A5);
    chk("bq_dlv_instr", instr,             32'hC0DE50A5);

    // Squash in DELIVER (A5 -> 010), then stalled squash at 010 -> 020.
    branch_taken = 1'b1; branch_target = 8'h10;
    tick();
    branch_taken = 1'b0;
    chk("bd1_valid", {31'b0, instr_valid}, 32'h0);
    chk("bd1_addr",  {20'b0, imem_addr},   32'h010);
    tick();
    chk("bd1_ipc",   {20'b0, instr_pc},    32'h010);
    branch_taken = 1'b1; branch_target = 8'h20; stall = 1'b1;
    #1;
    chk("bd2_pcsel1", {31'b0, pc_sel}, 32'h1);
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    #1;
    chk("bd2_pcsel0", {31'b0, pc_sel},      32'h0);
    chk("bd2_valid",  {31'b0, instr_valid}, 32'h0);
    chk("bd2_req",    {31'b0, imem_req},    32'h1);
    chk("bd2_addr",   {20'b0, imem_addr},   32'h020);
    tick();
    chk("bd2_ipc",    {20'b0, instr_pc},    32'h020);

    // Halt on consume at pc 003.
    branch_taken = 1'b1; branch_target = 8'h03;
    tick();
    branch_taken = 1'b0;
    chk("h_addr", {20'b0, imem_addr}, 32'h003);
    tick();
    chk("h_ipc",  {20'b0, instr_pc},  32'h003);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("h_halted", {31'b0, halted},      32'h1);
    chk("h_valid",  {31'b0, instr_valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("h_fcnt", {16'b0, fetch_cnt},  32'd7);
    chk("h_scnt", {16'b0, squash_cnt}, 32'd4);
`endif
    for (int k = 0; k < 20; k++) begin
      branch_taken = (k == 5);
      branch_target = 8'h40;
      #1;
      chk("h_pcsel", {31'b0, pc_sel},   32'h0);
      chk("h_noreq", {31'b0, imem_req}, 32'h0);
      chk("h_hold",  {31'b0, halted},   32'h1);
      tick();
    end
    branch_taken = 1'b0;

    // Asynchronous reset out of HALTED, then mid-REQ.
    #2 rst = 1'b1;
    #1;
    chk("ar1_halted", {31'b0, halted},      32'h0);
    chk("ar1_valid",  {31'b0, instr_valid}, 32'h0);
    chk("ar1_ipc",    {20'b0, instr_pc},    32'h0);
    chk("ar1_instr",  instr,                32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar1_req",  {31'b0, imem_req},  32'h1);
    chk("ar1_addr", {20'b0, imem_addr}, 32'h000);
    ack_en = 1'b0;
    tick();
    chk("ar2_wait", {31'b0, imem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("ar2_req",    {31'b0, imem_req}, 32'h0);
    chk("ar2_halted", {31'b0, halted},   32'h0);
    tick();
    rst = 1'b0; ack_en = 1'b1;
    tick();
    chk("ar2_rreq",  {31'b0, imem_req},  32'h1);
    chk("ar2_raddr", {20'b0, imem_addr}, 32'h000);
    tick();
    chk("ar2_valid", {31'b0, instr_valid}, 32'h1);
    chk("ar2_instr", instr,                32'hC0DE5000);

    // PC wrap from 12'hFFF on a second instance.
    rst2 = 1'b0;
    tick();
    chk("w_req",   {31'b0, imem_req2},  32'h1);
    chk("w_addr",  {20'b0, imem_addr2}, 32'hFFF);
    tick();
    chk("w_valid", {31'b0, instr_valid2}, 32'h1);
    chk("w_ipc",   {20'b0, instr_pc2},    32'hFFF);
    chk("w_instr", instr2,                32'hC0DE5FFF);
    tick();
    chk("w_wreq",  {31'b0, imem_req2},  32'h1);
    chk("w_waddr", {20'b0, imem_addr2}, 32'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
